// File: rtl/spi_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_dispatch_pkg
//  Description : Shared types and constants for the SPI operation dispatcher.
//                Holds the FSM state and target encodings, the opcode map,
//                the serial frame lengths and the opcode router.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_dispatch_pkg;

  // Dispatcher FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_OUT = 3'd1,
    ST_TURN      = 3'd2,
    ST_SHIFT_IN  = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // Remote slave that services an opcode
  typedef enum logic [1:0] {
    TGT_ALU  = 2'd0,
    TGT_MUL  = 2'd1,
    TGT_BAS  = 2'd2,
    TGT_NONE = 2'd3
  } target_t;

  // Opcode map
  localparam logic [3:0] c_OP_ALU_FIRST = 4'h0;
  localparam logic [3:0] c_OP_ALU_LAST  = 4'h5;
  localparam logic [3:0] c_OP_BAS_FIRST = 4'h6;
  localparam logic [3:0] c_OP_BAS_LAST  = 4'h7;
  localparam logic [3:0] c_OP_MUL       = 4'h9;

  // Frame geometry: command = {op, a, b}, response = 32-bit result
  localparam int unsigned c_FRAME_OUT_BITS = 68;
  localparam int unsigned c_FRAME_IN_BITS  = 32;
  localparam int unsigned c_BIT_CNT_W      = 7;

  // Route an opcode to the slave that implements it
  function automatic target_t decode_target(input logic [3:0] op);
    target_t t;
    t = TGT_NONE;
    if (op >= c_OP_ALU_FIRST && op <= c_OP_ALU_LAST) begin
      t = TGT_ALU;
    end else if (op >= c_OP_BAS_FIRST && op <= c_OP_BAS_LAST) begin
      t = TGT_BAS;
    end else if (op == c_OP_MUL) begin
      t = TGT_MUL;
    end
    return t;
  endfunction

  // Active-high select mask for a target: bit0 ALU, bit1 MUL, bit2 BAS
  function automatic logic [2:0] target_sel_mask(input target_t t);
    logic [2:0] m;
    case (t)
      TGT_ALU: m = 3'b001;
      TGT_MUL: m = 3'b010;
      TGT_BAS: m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sclk_gen
//  Description : Serial clock generator. Divides clk by CLK_DIV per half
//                period and emits single-cycle strobes marking the clk edge
//                at which sclk rises or falls. While disabled the divider is
//                held in its idle phase (sclk low). i_quiet keeps the pin low
//                while the strobes keep running, so idle bit periods can be
//                timed without toggling the line.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_quiet,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLK_DIV - 1);

  logic [c_CNT_W-1:0] r_div_cnt;
  logic               r_phase;
  logic               w_tick;

  assign w_tick = i_en && (r_div_cnt == c_LAST);
  assign o_rise = w_tick && !r_phase;
  assign o_fall = w_tick && r_phase;
  assign o_sclk = r_phase && !i_quiet;

  // Half-period divider; the phase flips every CLK_DIV enabled cycles
  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_op_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : spi_op_dispatcher
//  Description : Accepts an {op, a, b} request, routes it to one of three SPI
//                slaves (ALU, multiplier, barrel shifter), sends the 68-bit
//                command frame, waits a turnaround gap, reads back a 32-bit
//                result and presents it on a valid/ready response port.
//                Illegal opcodes are answered immediately with an error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_op_dispatcher
  import spi_dispatch_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned TURNAROUND = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic [2:0]  o_cs_n,
  input  logic [2:0]  i_miso,
  output logic        o_busy
);

  localparam logic [c_BIT_CNT_W-1:0] c_OUT_LAST  = c_BIT_CNT_W'(c_FRAME_OUT_BITS - 1);
  localparam logic [c_BIT_CNT_W-1:0] c_TURN_LAST = c_BIT_CNT_W'(TURNAROUND - 1);
  localparam logic [c_BIT_CNT_W-1:0] c_IN_DONE   = c_BIT_CNT_W'(c_FRAME_IN_BITS);

  state_t                 r_state;
  state_t                 w_next_state;
  target_t                r_target;
  logic [67:0]            r_frame;
  logic [31:0]            r_rx;
  logic [c_BIT_CNT_W-1:0] r_bit_cnt;
  logic [31:0]            r_rsp_data;
  logic                   r_rsp_err;

  target_t                w_req_target;
  logic                   w_req_legal;
  logic                   w_accept;
  logic                   w_in_done;
  logic                   w_sclk_en;
  logic                   w_sclk_quiet;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_miso_bit;

  assign w_req_target = decode_target(i_req_op);
  assign w_req_legal  = (w_req_target != TGT_NONE);
  assign w_accept     = i_req_valid && (r_state == ST_IDLE);
  // All 32 response bits are in; the following edge closes the transaction
  assign w_in_done    = (r_state == ST_SHIFT_IN) && (r_bit_cnt == c_IN_DONE);

  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_err    = r_rsp_err;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_sclk_en),
    .i_quiet (w_sclk_quiet),
    .o_sclk  (o_sclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Pick the miso line of the slave owning the current transaction
  always_comb begin
    w_miso_bit = 1'b0;
    case (r_target)
      TGT_ALU: w_miso_bit = i_miso[0];
      TGT_MUL: w_miso_bit = i_miso[1];
      TGT_BAS: w_miso_bit = i_miso[2];
      default: w_miso_bit = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; every serial phase ends on the falling sclk strobe
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = w_req_legal ? ST_SHIFT_OUT : ST_RESP;
        end
      end
      ST_SHIFT_OUT: begin
        if (w_fall && (r_bit_cnt == c_OUT_LAST)) begin
          w_next_state = ST_TURN;
        end
      end
      ST_TURN: begin
        if (w_fall && (r_bit_cnt == c_TURN_LAST)) begin
          w_next_state = ST_SHIFT_IN;
        end
      end
      ST_SHIFT_IN: begin
        if (w_in_done) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    o_req_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    o_busy       = 1'b1;
    o_cs_n       = 3'b111;
    o_mosi       = 1'b0;
    w_sclk_en    = 1'b0;
    w_sclk_quiet = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
      end
      ST_SHIFT_OUT: begin
        o_cs_n    = ~target_sel_mask(r_target);
        o_mosi    = r_frame[67];
        w_sclk_en = 1'b1;
      end
      ST_TURN: begin
        o_cs_n       = ~target_sel_mask(r_target);
        w_sclk_en    = 1'b1;
        w_sclk_quiet = 1'b1;
      end
      ST_SHIFT_IN: begin
        o_cs_n    = ~target_sel_mask(r_target);
        w_sclk_en = !w_in_done;
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
      end
      default: begin
        o_busy = 1'b1;
      end
    endcase
  end

  // Bit/period counter: cleared on every state change, counts sclk periods
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_bit_cnt <= '0;
    end else if (w_fall && (r_state == ST_SHIFT_OUT || r_state == ST_TURN ||
                            r_state == ST_SHIFT_IN)) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // Command frame, target latch and receive shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_target <= TGT_NONE;
      r_frame  <= '0;
      r_rx     <= '0;
    end else if (w_accept) begin
      r_target <= w_req_target;
      r_frame  <= w_req_legal ? {i_req_op, i_req_a, i_req_b} : 68'd0;
      r_rx     <= '0;
    end else begin
      // mosi advances on the falling strobe so it only moves while sclk is low
      if (r_state == ST_SHIFT_OUT && w_fall) begin
        r_frame <= {r_frame[66:0], 1'b0};
      end
      // sample the slave on the rising strobe, MSB first
      if (r_state == ST_SHIFT_IN && w_rise) begin
        r_rx <= {r_rx[30:0], w_miso_bit};
      end
    end
  end

  // Response registers, frozen for the whole RESP state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_rsp_data <= '0;
      r_rsp_err  <= !w_req_legal;
    end else if (w_in_done) begin
      r_rsp_data <= r_rx;
      r_rsp_err  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_op_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_op_dispatcher
//  Description : Self-checking bench for spi_op_dispatcher with behavioural
//                SPI slaves and a directed plus random stimulus sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_op_dispatcher;

  localparam int unsigned CLK_DIV = 1;
  localparam int unsigned TA      = 4;
  localparam int          LAT     = 2 * CLK_DIV * (100 + TA) + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_a = 32'h0;
  logic [31:0] req_b = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        sclk;
  logic        mosi;
  logic [2:0]  cs_n;
  logic [2:0]  miso;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  spi_op_dispatcher #(
    .CLK_DIV    (CLK_DIV),
    .TURNAROUND (TA)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_sclk      (sclk),
    .o_mosi      (mosi),
    .o_cs_n      (cs_n),
    .i_miso      (miso),
    .o_busy      (busy)
  );

  // Result each remote slave computes for a command
  function automatic logic [31:0] slave_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~(a & b);
      4'h6: return a << b[4:0];
      4'h7: return a >> b[4:0];
      4'h9: return a * b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Expected chip-select pattern while a command is in flight
  function automatic logic [2:0] expected_cs(input logic [3:0] op);
    if (op <= 4'h5) return 3'b110;
    if (op == 4'h6 || op == 4'h7) return 3'b011;
    if (op == 4'h9) return 3'b101;
    return 3'b111;
  endfunction

  // Behavioural SPI slave, mode 0: receive 68 bits, answer with 32 bits
  logic        miso_bit = 1'b0;
  logic [67:0] rx_frame = '0;
  logic [31:0] tx_word = '0;
  int          rx_cnt = 0;
  int          tx_sent = 0;
  int          sclk_rises = 0;
  logic        sclk_q = 1'b0;
  logic        cs_q = 1'b0;
  logic        cs_any;

  assign cs_any = (cs_n != 3'b111);
  // unselected slaves drive the inverse so a wrong select corrupts the data
  assign miso = {cs_n[2] ? ~miso_bit : miso_bit,
                 cs_n[1] ? ~miso_bit : miso_bit,
                 cs_n[0] ? ~miso_bit : miso_bit};

  always @(sclk or cs_any) begin
    if (cs_any && !cs_q) begin
      rx_cnt   = 0;
      tx_sent  = 0;
      rx_frame = '0;
    end
    if (sclk && !sclk_q) begin
      sclk_rises++;
      if (rx_cnt < 68) begin
        rx_frame = {rx_frame[66:0], mosi};
        rx_cnt++;
        if (rx_cnt == 68) tx_word = slave_model(rx_frame[67:64], rx_frame[63:32], rx_frame[31:0]);
      end else begin
        tx_sent++;
      end
    end
    if (!sclk && sclk_q && rx_cnt == 68 && tx_sent < 32) miso_bit = tx_word[31 - tx_sent];
    sclk_q = sclk;
    cs_q   = cs_any;
  end

  // Line-protocol monitor: mosi steady while sclk high, at most one select low
  int   mosi_viol = 0;
  int   cs_viol = 0;
  logic mon_sclk = 1'b0;
  logic mon_mosi = 1'b0;

  always @(negedge clk) begin
    if (sclk && mon_sclk && (mosi !== mon_mosi)) mosi_viol++;
    if ($countones(~cs_n) > 1) cs_viol++;
    mon_sclk = sclk;
    mon_mosi = mosi;
  end

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete request/response transaction with response back-pressure
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    int          cyc;
    int          rises0;
    logic        legal;
    logic        stable;
    logic [31:0] d0;
    logic        e0;
    legal = (expected_cs(op) != 3'b111);
    @(negedge clk);
    check("req_ready_idle", 68'(req_ready), 68'(1));
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rises0    = sclk_rises;
    cyc       = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_valid = 1'b0;
        check("cs_n_select", 68'(cs_n), 68'(expected_cs(op)));
      end
    end while (!rsp_valid && cyc < 2000);
    check("rsp_latency", 68'(cyc), legal ? 68'(LAT) : 68'(1));
    check("rsp_err", 68'(rsp_err), 68'(!legal));
    check("rsp_data", 68'(rsp_data), legal ? 68'(slave_model(op, a, b)) : 68'(0));
    if (legal) check("mosi_frame", rx_frame, {op, a, b});
    else       check("sclk_quiet_illegal", 68'(sclk_rises - rises0), 68'(0));
    stable = 1'b1;
    d0     = rsp_data;
    e0     = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d0 || rsp_err !== e0 || req_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check("rsp_hold_stable", 68'(stable), 68'(1));
    // handshake cycle, with a competing request that must not be taken
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_op    = 4'h0;
    check("no_accept_in_handshake", 68'(req_ready), 68'(0));
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("idle_after_handshake", 68'({busy, req_ready, rsp_valid}), 68'(3'b010));
  endtask

  initial begin
    int   guard;
    logic seen_rsp;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_cs_n", 68'(cs_n), 68'(3'b111));
    check("reset_lines", 68'({sclk, mosi, busy, rsp_valid, rsp_err}), 68'(0));
    check("reset_rsp_data", 68'(rsp_data), 68'(0));
    check("reset_req_ready", 68'(req_ready), 68'(1));
    rst = 1'b0;

    // Directed operations
    do_op(4'h0, 32'd5, 32'd7, 0);             // ADD -> 0xC
    do_op(4'h9, 32'd3, 32'h10, 1);            // MUL -> 0x30
    do_op(4'h8, 32'h1234, 32'h5678, 2);       // illegal
    do_op(4'h7, 32'hF000_0000, 32'd4, 10);    // SHR with back-pressure
    do_op(4'hF, 32'hFFFF_FFFF, 32'd1, 0);     // illegal, top opcode

    // Reset in the middle of the command frame
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'h0;
    req_a     = 32'hAAAA_5555;
    req_b     = 32'h0F0F_F0F0;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (rx_cnt < 20 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("reach_bit20", 68'(rx_cnt), 68'(20));
    rst = 1'b1;
    @(negedge clk);
    check("abort_lines", 68'({cs_n, sclk, busy, rsp_valid}), 68'(7'b111_0_0_0));
    rst = 1'b0;
    seen_rsp = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp = 1'b1;
    end
    check("no_rsp_after_abort", 68'(seen_rsp), 68'(0));
    do_op(4'h0, 32'd5, 32'd7, 0);

    // Random operations
    for (int k = 0; k < 8; k++) begin
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    check("mosi_stable_sclk_high", 68'(mosi_viol), 68'(0));
    check("cs_n_at_most_one", 68'(cs_viol), 68'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
